// File: rtl/cntr_param.sv
// Parametrised loadable up/down counter with boundary flags and one-cycle overflow pulse.
// Define CNTR_SAT_EN to build a saturating counter instead of the default modulo-2^WIDTH wrap.
module cntr_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [2:0]       o_state,
  output logic             o_zero,
  output logic             o_max,
  output logic             o_ovf
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam logic [W1-1:0]    STEP_EXT = W1'(STEP);
  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LOAD = 3'b001,
    INC  = 3'b010,
    INC2 = 3'b011,
    DEC  = 3'b100,
    DEC2 = 3'b101
  } state_t;

  // Held as raw bits so the two unused encodings can be recognised and recovered.
  logic [2:0]       state;
  logic [WIDTH-1:0] count;
  logic             ovf;

  logic [W1-1:0]    sum;
  logic [W1-1:0]    diff;
  logic             carry;
  logic             borrow;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;

  // Extra top bit of the WIDTH+1 result flags a boundary crossing.
  assign sum    = {1'b0, count} + STEP_EXT;
  assign diff   = {1'b0, count} - STEP_EXT;
  assign carry  = sum[WIDTH];
  assign borrow = diff[WIDTH];

`ifdef CNTR_SAT_EN
  assign up_val = carry  ? MAX_VAL : sum[WIDTH-1:0];
  assign dn_val = borrow ? '0      : diff[WIDTH-1:0];
`else
  assign up_val = sum[WIDTH-1:0];
  assign dn_val = diff[WIDTH-1:0];
`endif

  // State register, next-state selection and count datapath.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE, LOAD, INC, INC2, DEC, DEC2: begin
          if (load) begin
            state <= LOAD;
            count <= d_in;
            ovf   <= 1'b0;
          end else if (inc) begin
            state <= (state == INC) ? INC2 : INC;
            count <= up_val;
            ovf   <= carry;
          end else begin
            state <= (state == DEC) ? DEC2 : DEC;
            count <= dn_val;
            ovf   <= borrow;
          end
        end
        default: begin
          state <= IDLE;
          ovf   <= 1'b0;
        end
      endcase
    end
  end

  assign d_out   = count;
  assign o_state = state;
  assign o_ovf   = ovf;
  assign o_zero  = (count == '0);
  assign o_max   = (count == MAX_VAL);

endmodule

// File: tb/tb_cntr_param.sv
// Directed bench for cntr_param: an 8-bit STEP=1 instance and a 4-bit STEP=5 instance.
// Expected values follow the wrap build, or the saturating build when CNTR_SAT_EN is defined.
module tb_cntr_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       load;
  logic       inc;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic [2:0] o_state;
  logic       o_zero;
  logic       o_max;
  logic       o_ovf;

  logic       load4;
  logic       inc4;
  logic [3:0] d_in4;
  logic [3:0] d_out4;
  logic [2:0] o_state4;
  logic       o_zero4;
  logic       o_max4;
  logic       o_ovf4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cntr_param #(.WIDTH(8), .STEP(1)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .inc(inc), .d_in(d_in),
    .d_out(d_out), .o_state(o_state), .o_zero(o_zero), .o_max(o_max), .o_ovf(o_ovf)
  );

  cntr_param #(.WIDTH(4), .STEP(5)) dut4 (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load4), .inc(inc4), .d_in(d_in4),
    .d_out(d_out4), .o_state(o_state4), .o_zero(o_zero4), .o_max(o_max4), .o_ovf(o_ovf4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] exp_d, input logic [2:0] exp_s,
                        input logic exp_ovf);
    check({tag, ".d_out"}, 32'(d_out), 32'(exp_d));
    check({tag, ".state"}, 32'(o_state), 32'(exp_s));
    check({tag, ".ovf"}, 32'(o_ovf), 32'(exp_ovf));
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; load = 1'b1; inc = 1'b0; d_in = 8'h55;
    load4 = 1'b0; inc4 = 1'b0; d_in4 = 4'h0;

    // Reset held for two edges while a load is requested
    tick(); tick();
    check8("rst", 8'h00, 3'b000, 1'b0);
    check("rst.zero", 32'(o_zero), 32'd1);
    check("rst.max", 32'(o_max), 32'd0);
    check("rst4.d_out", 32'(d_out4), 32'h0);

    // Load then count up across the top
    reset_n = 1'b1; load = 1'b1; d_in = 8'hFD;
    tick(); check8("ld_fd", 8'hFD, 3'b001, 1'b0);
    load = 1'b0; inc = 1'b1;
    tick(); check8("up1", 8'hFE, 3'b010, 1'b0);
    tick(); check8("up2", 8'hFF, 3'b011, 1'b0);
    check("up2.max", 32'(o_max), 32'd1);
`ifdef CNTR_SAT_EN
    tick(); check8("up3", 8'hFF, 3'b010, 1'b1);
    check("up3.zero", 32'(o_zero), 32'd0);
`else
    tick(); check8("up3", 8'h00, 3'b010, 1'b1);
    check("up3.zero", 32'(o_zero), 32'd1);
`endif

    // Pending overflow pulse survives a disabled edge
    en = 1'b0;
    tick();
`ifdef CNTR_SAT_EN
    check8("hold_ovf", 8'hFF, 3'b010, 1'b1);
`else
    check8("hold_ovf", 8'h00, 3'b010, 1'b1);
`endif
    en = 1'b1;

    // Down count through zero
    load = 1'b1; inc = 1'b0; d_in = 8'h02;
    tick(); check8("ld_02", 8'h02, 3'b001, 1'b0);
    load = 1'b0;
    tick(); check8("dn1", 8'h01, 3'b100, 1'b0);
    check("dn1.zero", 32'(o_zero), 32'd0);
    tick(); check8("dn2", 8'h00, 3'b101, 1'b0);
    check("dn2.zero", 32'(o_zero), 32'd1);
`ifdef CNTR_SAT_EN
    tick(); check8("dn3", 8'h00, 3'b100, 1'b1);
    check("dn3.zero", 32'(o_zero), 32'd1);
`else
    tick(); check8("dn3", 8'hFF, 3'b100, 1'b1);
    check("dn3.zero", 32'(o_zero), 32'd0);
`endif

    // Load beats inc; then enable low freezes everything
    load = 1'b1; inc = 1'b1; d_in = 8'h40;
    tick(); check8("prio", 8'h40, 3'b001, 1'b0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); check8("en_off", 8'h40, 3'b001, 1'b0);
    end
    en = 1'b1;

    // Back-to-back loads stay in LOAD
    load = 1'b1; d_in = 8'h11;
    tick(); check8("bb1", 8'h11, 3'b001, 1'b0);
    d_in = 8'h22;
    tick(); check8("bb2", 8'h22, 3'b001, 1'b0);

    // Reset in the middle of an up count
    d_in = 8'h79;
    tick();
    load = 1'b0; inc = 1'b1;
    tick(); check8("mid_up", 8'h7A, 3'b010, 1'b0);
    reset_n = 1'b0;
    tick(); check8("mid_rst", 8'h00, 3'b000, 1'b0);
    reset_n = 1'b1;
    tick(); check8("post_rst", 8'h01, 3'b010, 1'b0);

    // WIDTH=4, STEP=5 instance
    load4 = 1'b1; d_in4 = 4'hC;
    tick();
    check("w4_ld.d_out", 32'(d_out4), 32'hC);
    check("w4_ld.state", 32'(o_state4), 32'h1);
    load4 = 1'b0; inc4 = 1'b1;
    tick();
`ifdef CNTR_SAT_EN
    check("w4_up.d_out", 32'(d_out4), 32'hF);
    check("w4_up.max", 32'(o_max4), 32'd1);
`else
    check("w4_up.d_out", 32'(d_out4), 32'h1);
    check("w4_up.max", 32'(o_max4), 32'd0);
`endif
    check("w4_up.ovf", 32'(o_ovf4), 32'd1);
    check("w4_up.state", 32'(o_state4), 32'h2);
    tick();
`ifdef CNTR_SAT_EN
    check("w4_up2.d_out", 32'(d_out4), 32'hF);
    check("w4_up2.ovf", 32'(o_ovf4), 32'd1);
`else
    check("w4_up2.d_out", 32'(d_out4), 32'h6);
    check("w4_up2.ovf", 32'(o_ovf4), 32'd0);
`endif
    check("w4_up2.state", 32'(o_state4), 32'h3);
    load4 = 1'b1; inc4 = 1'b0; d_in4 = 4'h3;
    tick();
    load4 = 1'b0;
    tick();
`ifdef CNTR_SAT_EN
    check("w4_dn.d_out", 32'(d_out4), 32'h0);
`else
    check("w4_dn.d_out", 32'(d_out4), 32'hE);
`endif
    check("w4_dn.ovf", 32'(o_ovf4), 32'd1);
    check("w4_dn.state", 32'(o_state4), 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cntr_param.md
# cntr_param

Parametrised loadable up/down counter: state register, next-state logic and count datapath in one block. Generalises the fixed 8-bit counter to any WIDTH and STEP, with a clock enable, boundary flags and a one-cycle overflow pulse. Sits wherever the design needs a loadable event or address counter driven by `load`/`inc` control.

## Interface
- `WIDTH`, default 8: count width in bits, 2..32.
- `STEP`, default 1: increment/decrement amount, 1..2^WIDTH−1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `en` input 1: clock enable; 0 holds all registers.
- `load` input 1: load request; highest priority.
- `inc` input 1: direction when not loading; 1 = up, 0 = down.
- `d_in` input WIDTH: load value.
- `d_out` output WIDTH: current count, registered.
- `o_state` output 3: current FSM state, registered.
- `o_zero` output 1: `d_out == 0`, combinational from the register.
- `o_max` output 1: `d_out == 2^WIDTH−1`, combinational from the register.
- `o_ovf` output 1: registered one-cycle pulse; last update crossed a boundary.

## Operation
- Encoding: IDLE=000, LOAD=001, INC=010, INC2=011, DEC=100, DEC2=101; 110/111 illegal.
- Next state, all legal states: `load`=1 -> LOAD; else `inc`=1 -> INC, except INC -> INC2; else DEC, except DEC -> DEC2.
- INC and INC2 alternate while `inc` holds. DEC and DEC2 alternate while `inc` is low.
- Illegal state: next state is IDLE and count holds. Never X.
- `load` and `inc` are both taken as 0/1. X/Z on these inputs is not supported.
- Count update, selected by next state:
  - LOAD: count <= `d_in`.
  - INC, INC2: count <= count + STEP.
  - DEC, DEC2: count <= count − STEP.
  - IDLE: hold.
- Arithmetic uses WIDTH+1 bits. The carry/borrow bit is the boundary-crossing indicator.
- Wrap, without the macro: the result is the low WIDTH bits, and `o_ovf` <= 1 on the same edge.
  - Example, WIDTH=8, STEP=3: 254+3 -> 1; 1−3 -> 254.
- `o_ovf` <= 0 on every enabled edge with no crossing, including LOAD and IDLE.
- `o_zero` and `o_max` carry no state of their own.

## Timing
- Reset values: `o_state`=IDLE, `d_out`=0, `o_ovf`=0. As a consequence `o_zero`=1 and `o_max`=0.
- Reset has priority over `en`. Asserting reset mid-count returns to the reset values on that edge, with no partial update.
- Latency: inputs sampled at edge N; `o_state`, `d_out` and `o_ovf` are valid after edge N. One cycle, no pipelining.
- `en`=0: state, count and `o_ovf` all hold. A pending `o_ovf`=1 stays high until the next enabled edge.
- `load` and `inc` asserted together: `load` wins, `inc` is ignored that cycle.
- Back-to-back loads keep the state at LOAD; each edge reloads `d_in`.
- Leaving LOAD or IDLE always enters INC or DEC first, never INC2 or DEC2.

## Configuration
- Macro: `CNTR_SAT_EN`.
- Defined: saturating counter.
  - An increment that would exceed 2^WIDTH−1 clamps to 2^WIDTH−1.
  - A decrement below 0 clamps to 0.
  - `o_ovf` pulses on the clamping edge.
  - The FSM still alternates INC/INC2 or DEC/DEC2 while clamped.
- Undefined: modulo-2^WIDTH wrap as described under Operation.
- State transitions, reset values and latency are identical in both builds.

## Test plan
All scenarios use WIDTH=8, STEP=1 unless noted.
- Reset: hold `reset_n`=0 for 2 edges with `load`=1 and `d_in`=0x55 -> `d_out`=0, `o_state`=000, `o_zero`=1, `o_ovf`=0.
- Load then count: load 0xFD, then `inc`=1 for 3 edges.
  - `d_out` = FD, FE, FF, 00.
  - `o_state` = 001, 010, 011, 010.
  - `o_ovf`=1 only after the FF->00 edge.
  - With `CNTR_SAT_EN`, the last step gives `d_out`=FF and `o_ovf`=1.
- Down count: from 0x02 with `inc`=0 for 3 edges.
  - `d_out` = 01, 00, FF.
  - `o_state` = 100, 101, 100.
  - `o_zero` is high for exactly one cycle.
- Priority and enable:
  - `load`=1, `inc`=1, `d_in`=0x40 -> `d_out`=40, state LOAD.
  - Then `en`=0 for 4 edges with `inc`=1 -> `d_out` and `o_state` unchanged.
- Reset mid-operation: counting up at 0x7A, pull `reset_n` low for one edge -> next `d_out`=00 and state IDLE. The following edge with `inc`=1 gives 01 and INC.
- WIDTH=4, STEP=5: load 0xC, increment -> 0x1 with `o_ovf`=1. With `CNTR_SAT_EN` -> 0xF with `o_ovf`=1.
